vga_timing_ctrl: RTL and testbench

Programmable VGA raster timing controller that configures and sequences the horizontal and vertical sync counters. Software-style register writes load a staging bank of eight 12-bit timing fields. A commit moves them to the active bank only at a frame boundary, so no torn frames are ever produced. The block drives hsync/vsync, the data-enable window and pixel coordinates to the pixel pipeline and DAC.

---
 rtl/vga_timing_ctrl.sv | 148 ++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
// Programmable VGA raster timing: staged/active timing banks, frame-boundary commit,
// and registered hsync/vsync/de/xpos/ypos/frame_start generation.
module vga_timing_ctrl #(
  parameter logic [11:0] H_VIS_DEF = 12'd640,
  parameter logic [11:0] H_FP_DEF  = 12'd16,
  parameter logic [11:0] H_SP_DEF  = 12'd96,
  parameter logic [11:0] H_BP_DEF  = 12'd48,
  parameter logic [11:0] V_VIS_DEF = 12'd480,
  parameter logic [11:0] V_FP_DEF  = 12'd10,
  parameter logic [11:0] V_SP_DEF  = 12'd2,
  parameter logic [11:0] V_BP_DEF  = 12'd33
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        cfg_wr_en,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        cfg_busy,
  output logic        cfg_err,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        frame_start
);

  logic [11:0] stg    [8];
  logic [11:0] act    [8];
  logic [11:0] stg_nx [8];

  logic [11:0] h_cnt, v_cnt;
  logic [12:0] h_total, v_total;
  logic [12:0] h_fp_end, h_sp_end, v_fp_end, v_sp_end;
  logic [13:0] stg_h_sum, stg_v_sum;
  logic        stg_ok, wr_ok, h_last, v_last, apply;
  logic        in_h_vis, in_v_vis, in_h_sync, in_v_sync;

  function automatic logic [11:0] def_field(input int idx);
    case (idx)
      0:       return H_VIS_DEF;
      1:       return H_FP_DEF;
      2:       return H_SP_DEF;
      3:       return H_BP_DEF;
      4:       return V_VIS_DEF;
      5:       return V_FP_DEF;
      6:       return V_SP_DEF;
      default: return V_BP_DEF;
    endcase
  endfunction

  assign wr_ok = cfg_wr_en && !cfg_busy;

  // Staging bank as it will look after this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    for (int i = 0; i < 8; i++) stg_nx[i] = stg[i];
    if (wr_ok) stg_nx[cfg_addr] = cfg_wdata;
  end

  assign stg_h_sum = 14'(stg_nx[0]) + 14'(stg_nx[1]) + 14'(stg_nx[2]) + 14'(stg_nx[3]);
  assign stg_v_sum = 14'(stg_nx[4]) + 14'(stg_nx[5]) + 14'(stg_nx[6]) + 14'(stg_nx[7]);

  always_comb begin
    stg_ok = (stg_h_sum <= 14'd4095) && (stg_v_sum <= 14'd4095);
    for (int i = 0; i < 8; i++) begin
      if (stg_nx[i] == 12'd0) stg_ok = 1'b0;
    end
  end

  assign h_fp_end = 13'(act[0]) + 13'(act[1]);
  assign h_sp_end = h_fp_end + 13'(act[2]);
  assign h_total  = h_sp_end + 13'(act[3]);
  assign v_fp_end = 13'(act[4]) + 13'(act[5]);
  assign v_sp_end = v_fp_end + 13'(act[6]);
  assign v_total  = v_sp_end + 13'(act[7]);

  assign in_h_vis  = h_cnt < act[0];
  assign in_v_vis  = v_cnt < act[4];
  assign in_h_sync = ({1'b0, h_cnt} >= h_fp_end) && ({1'b0, h_cnt} < h_sp_end);
  assign in_v_sync = ({1'b0, v_cnt} >= v_fp_end) && ({1'b0, v_cnt} < v_sp_end);
  assign h_last    = {1'b0, h_cnt} == (h_total - 13'd1);
  assign v_last    = {1'b0, v_cnt} == (v_total - 13'd1);

  // A parked raster has no frame in flight, so a pending commit may land immediately.
  assign apply = cfg_busy && (!run || (h_last && v_last));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        stg[i] <= def_field(i);
        act[i] <= def_field(i);
      end
      h_cnt       <= '0;
      v_cnt       <= '0;
      cfg_busy    <= 1'b0;
      cfg_err     <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
      frame_start <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      for (int i = 0; i < 8; i++) stg[i] <= stg_nx[i];

      if (cfg_commit && !cfg_busy) begin
        if (stg_ok) cfg_busy <= 1'b1;
        else        cfg_err  <= 1'b1;
      end

      if (apply) begin
        for (int i = 0; i < 8; i++) act[i] <= stg[i];
        cfg_busy <= 1'b0;
      end

      if (!run) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? 12'd0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end

      // Output stage: decode of the current counters, one cycle behind them.
      if (!run) begin
        hsync       <= 1'b1;
        vsync       <= 1'b1;
        de          <= 1'b0;
        frame_start <= 1'b0;
      end else begin
        hsync       <= !in_h_sync;
        vsync       <= !in_v_sync;
        de          <= in_h_vis && in_v_vis;
        frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
        if (in_h_vis && in_v_vis) begin
          xpos <= h_cnt;
          ypos <= v_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: frame-sequence scoreboard built from phase lengths,
// plus config commit/reject, run park/restart and async reset scenarios.
module tb_vga_timing_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [11:0] cfg_wdata = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy, cfg_err, hsync, vsync, de, frame_start;
  logic [11:0] xpos, ypos;

  vga_timing_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .hsync(hsync), .vsync(vsync), .de(de), .xpos(xpos), .ypos(ypos), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] x;
    logic [11:0] y;
    logic        fs;
  } obs_t;

  obs_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [11:0] last_x = '0;
  logic [11:0] last_y = '0;

  function automatic obs_t observe();
    return obs_t'({hsync, vsync, de, xpos, ypos, frame_start});
  endfunction

  // Expected output stream for one frame, walked segment by segment (VIS, FP, SYNC, BP).
  task automatic push_frame(input int hv, input int hf, input int hs, input int hb,
                            input int vv, input int vf, input int vs, input int vb,
                            input int max_lines);
    int   hseg[4];
    int   vseg[4];
    int   ln;
    int   px;
    obs_t e;
    hseg = '{hv, hf, hs, hb};
    vseg = '{vv, vf, vs, vb};
    ln = 0;
    for (int sv = 0; sv < 4; sv++) begin
      for (int l = 0; l < vseg[sv]; l++) begin
        if (ln < max_lines) begin
          px = 0;
          for (int sh = 0; sh < 4; sh++) begin
            for (int p = 0; p < hseg[sh]; p++) begin
              e.de = (sh == 0) && (sv == 0);
              if (e.de) begin
                last_x = 12'(px);
                last_y = 12'(ln);
              end
              e.hs = (sh != 2);
              e.vs = (sv != 2);
              e.x  = last_x;
              e.y  = last_y;
              e.fs = (ln == 0) && (px == 0);
              exp_q.push_back(e);
              px++;
            end
          end
        end
        ln++;
      end
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    obs_t r;
    r = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0};
    repeat (3) @(negedge clk);
    total++;
    if (observe() !== r) begin
      bad++; $display("FAIL reset_outputs got=%h want=%h", observe(), r);
    end
    total++;
    if (cfg_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", cfg_busy); end
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg_err); end
  endtask

  task automatic test_default_lines();
    obs_t e, o, fo, fe;
    int   mism, idx, fi, de_cnt, hs_first, hs_len;
    rst = 1'b1;
    run = 1'b1;
    @(negedge clk);
    total++;
    if (frame_start !== 1'b1) begin
      bad++; $display("FAIL run_to_frame_start got=%b want=1", frame_start);
    end
    push_frame(640, 16, 96, 48, 480, 10, 2, 33, 3);
    mism = 0; idx = 0; fi = 0; fo = '0; fe = '0; de_cnt = 0; hs_first = -1; hs_len = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      if (idx < 800) begin
        if (o.de) de_cnt++;
        if (!o.hs) begin
          if (hs_first < 0) hs_first = idx;
          hs_len++;
        end
      end
      if (o !== e) begin
        if (mism == 0) begin fi = idx; fo = o; fe = e; end
        mism++;
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL default_lines %0d cycles differ, first at %0d got=%h want=%h", mism, fi, fo, fe);
    end
    total++;
    if (de_cnt !== 640) begin bad++; $display("FAIL default_de_width got=%0d want=640", de_cnt); end
    total++;
    if (hs_first !== 656) begin bad++; $display("FAIL default_hsync_start got=%0d want=656", hs_first); end
    total++;
    if (hs_len !== 96) begin bad++; $display("FAIL default_hsync_width got=%0d want=96", hs_len); end
  endtask

  task automatic test_bad_commit();
    int   n, t1, t2;
    logic prev;
    wr(3'd2, 12'd0);
    commit();
    total++;
    if ({cfg_err, cfg_busy} !== 2'b10) begin
      bad++; $display("FAIL zero_field_reject err,busy got=%b want=10", {cfg_err, cfg_busy});
    end
    @(negedge clk);
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b want=0", cfg_err); end
    wr(3'd2, 12'd96);

    wr(3'd0, 12'd4000);
    commit();
    total++;
    if ({cfg_err, cfg_busy} !== 2'b10) begin
      bad++; $display("FAIL total_overflow_reject err,busy got=%b want=10", {cfg_err, cfg_busy});
    end
    wr(3'd0, 12'd640);

    cfg_wr_en = 1'b1; cfg_addr = 3'd6; cfg_wdata = 12'd0; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    total++;
    if ({cfg_err, cfg_busy} !== 2'b10) begin
      bad++; $display("FAIL write_with_commit_reject err,busy got=%b want=10", {cfg_err, cfg_busy});
    end
    wr(3'd6, 12'd2);

    prev = hsync; n = 0; t1 = -1; t2 = -1;
    while (n < 2000 && t2 < 0) begin
      @(negedge clk);
      n++;
      if (prev === 1'b1 && hsync === 1'b0) begin
        if (t1 < 0) t1 = n;
        else        t2 = n;
      end
      prev = hsync;
    end
    total++;
    if ((t2 - t1) !== 800) begin
      bad++; $display("FAIL line_period_unchanged got=%0d want=800", t2 - t1);
    end
  endtask

  task automatic test_commit_park();
    obs_t e, o, fo, fe;
    int   mism, idx, fi, n;
    wr(3'd0, 12'd4); wr(3'd1, 12'd1); wr(3'd2, 12'd2); wr(3'd3, 12'd1);
    wr(3'd4, 12'd2); wr(3'd5, 12'd1); wr(3'd6, 12'd1); wr(3'd7, 12'd1);
    commit();
    total++;
    if ({cfg_busy, cfg_err} !== 2'b10) begin
      bad++; $display("FAIL commit_accept busy,err got=%b want=10", {cfg_busy, cfg_err});
    end
    wr(3'd0, 12'd100);
    commit();
    total++;
    if ({cfg_busy, cfg_err} !== 2'b10) begin
      bad++; $display("FAIL commit_while_busy busy,err got=%b want=10", {cfg_busy, cfg_err});
    end
    repeat (50) @(negedge clk);
    total++;
    if (cfg_busy !== 1'b1) begin bad++; $display("FAIL busy_held_midframe got=%b want=1", cfg_busy); end

    run = 1'b0;
    @(negedge clk);
    total++;
    if ({hsync, vsync, de, frame_start} !== 4'b1100) begin
      bad++; $display("FAIL run_off_outputs hs,vs,de,fs got=%b want=1100", {hsync, vsync, de, frame_start});
    end
    total++;
    if (cfg_busy !== 1'b0) begin bad++; $display("FAIL apply_when_parked got=%b want=0", cfg_busy); end
    repeat (3) @(negedge clk);

    run = 1'b1;
    n = 0;
    while (frame_start !== 1'b1 && n < 4) begin @(negedge clk); n++; end
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL small_frame_start got=%b want=1", frame_start); end
    push_frame(4, 1, 2, 1, 2, 1, 1, 1, 99);
    push_frame(4, 1, 2, 1, 2, 1, 1, 1, 99);
    mism = 0; idx = 0; fi = 0; fo = '0; fe = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      if (o !== e) begin
        if (mism == 0) begin fi = idx; fo = o; fe = e; end
        mism++;
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL small_frames %0d cycles differ, first at %0d got=%h want=%h", mism, fi, fo, fe);
    end
  endtask

  task automatic test_frame_boundary_apply();
    obs_t e, o, fo, fe;
    int   mism, idx, fi, n;
    logic p1, p2;
    wr(3'd0, 12'd3); wr(3'd1, 12'd2); wr(3'd2, 12'd1); wr(3'd3, 12'd2);
    wr(3'd4, 12'd3); wr(3'd5, 12'd1); wr(3'd6, 12'd2);
    cfg_wr_en = 1'b1; cfg_addr = 3'd7; cfg_wdata = 12'd2; cfg_commit = 1'b1;
    @(negedge clk);
    cfg_wr_en = 1'b0; cfg_commit = 1'b0;
    total++;
    if (cfg_busy !== 1'b1) begin bad++; $display("FAIL write_and_commit_busy got=%b want=1", cfg_busy); end

    p2 = 1'b0; p1 = cfg_busy; n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (frame_start === 1'b1) break;
      p2 = p1;
      p1 = cfg_busy;
    end
    total++;
    if ((n + 8) !== 40) begin bad++; $display("FAIL small_period got=%0d want=40", n + 8); end
    total++;
    if (p2 !== 1'b1) begin bad++; $display("FAIL busy_until_frame_end got=%b want=1", p2); end
    total++;
    if (p1 !== 1'b0) begin bad++; $display("FAIL busy_clear_at_wrap got=%b want=0", p1); end

    push_frame(3, 2, 1, 2, 3, 1, 2, 2, 99);
    mism = 0; idx = 0; fi = 0; fo = '0; fe = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      if (o !== e) begin
        if (mism == 0) begin fi = idx; fo = o; fe = e; end
        mism++;
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL new_mode_frame %0d cycles differ, first at %0d got=%h want=%h", mism, fi, fo, fe);
    end
  endtask

  task automatic test_run_restart();
    obs_t e, o, fo, fe;
    int   mism, idx, fi;
    repeat (2) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    total++;
    if ({hsync, vsync, de, frame_start} !== 4'b1100) begin
      bad++; $display("FAIL midline_stop hs,vs,de,fs got=%b want=1100", {hsync, vsync, de, frame_start});
    end
    total++;
    if (xpos !== 12'd2) begin bad++; $display("FAIL xpos_hold got=%0d want=2", xpos); end
    repeat (4) @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL restart_frame_start got=%b want=1", frame_start); end
    push_frame(3, 2, 1, 2, 3, 1, 2, 2, 99);
    mism = 0; idx = 0; fi = 0; fo = '0; fe = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      if (o !== e) begin
        if (mism == 0) begin fi = idx; fo = o; fe = e; end
        mism++;
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL restart_frame %0d cycles differ, first at %0d got=%h want=%h", mism, fi, fo, fe);
    end
  endtask

  task automatic test_reset_pending();
    obs_t e, o, fo, fe, r;
    int   mism, idx, fi, n;
    r = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: 12'd0, y: 12'd0, fs: 1'b0};
    repeat (5) @(negedge clk);
    commit();
    total++;
    if (cfg_busy !== 1'b1) begin bad++; $display("FAIL pending_before_reset got=%b want=1", cfg_busy); end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (observe() !== r) begin
      bad++; $display("FAIL async_reset_outputs got=%h want=%h", observe(), r);
    end
    total++;
    if (cfg_busy !== 1'b0) begin bad++; $display("FAIL async_reset_busy got=%b want=0", cfg_busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    last_x = '0;
    last_y = '0;
    n = 0;
    while (frame_start !== 1'b1 && n < 4) begin @(negedge clk); n++; end
    total++;
    if (frame_start !== 1'b1) begin bad++; $display("FAIL post_reset_start got=%b want=1", frame_start); end
    push_frame(640, 16, 96, 48, 480, 10, 2, 33, 2);
    mism = 0; idx = 0; fi = 0; fo = '0; fe = '0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = observe();
      if (o !== e) begin
        if (mism == 0) begin fi = idx; fo = o; fe = e; end
        mism++;
      end
      idx++;
      @(negedge clk);
    end
    total++;
    if (mism !== 0) begin
      bad++; $display("FAIL post_reset_default %0d cycles differ, first at %0d got=%h want=%h", mism, fi, fo, fe);
    end
  endtask

  initial begin
    test_reset();
    test_default_lines();
    test_bad_commit();
    test_commit_park();
    test_frame_boundary_apply();
    test_run_restart();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
